// File: rtl/nco_phase_config.sv
// nco_phase_config
//   Builds {POFF, PINC} configuration beats for an NCO AXI-Stream config port.
//   PINC = freq_base + sign-extended freq_adj (wraps modulo 2^PHASE_WIDTH).
//   One beat is emitted automatically after reset with the nominal carrier.
//   After that, each adj_valid pulse produces one beat. While a beat is stalled,
//   one update is parked in a pending slot, and newer updates replace it.
//
// Ports
//   clk          : single clock, rising edge
//   rst_n        : asynchronous active-low reset
//   freq_base    : unsigned nominal phase increment
//   freq_adj     : signed loop-filter correction
//   phase_off    : unsigned phase offset
//   adj_valid    : freq_adj / phase_off valid for one cycle
//   CFG_tdata    : {POFF, PINC} toward NCO config port
//   CFG_tvalid   : AXI-Stream valid
//   CFG_tready   : AXI-Stream ready
//   cfg_count    : accepted config beats (wraps at 2^16)
//   drop_count   : computed updates overwritten before being sent (wraps)
module nco_phase_config #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADJ_WIDTH   = 24
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [PHASE_WIDTH-1:0]        freq_base,
    input  logic signed [ADJ_WIDTH-1:0]   freq_adj,
    input  logic [PHASE_WIDTH-1:0]        phase_off,
    input  logic                          adj_valid,
    output logic [2*PHASE_WIDTH-1:0]      CFG_tdata,
    output logic                          CFG_tvalid,
    input  logic                          CFG_tready,
    output logic [15:0]                   cfg_count,
    output logic [15:0]                   drop_count
);

    typedef enum logic [1:0] {INIT, IDLE, SEND} state_t;

    // Wrapping add of the sign-extended correction; no saturation by design.
    function automatic logic [PHASE_WIDTH-1:0] pinc_wrap(
        input logic [PHASE_WIDTH-1:0]      base,
        input logic signed [ADJ_WIDTH-1:0] adj
    );
        logic [PHASE_WIDTH-1:0] adj_ext;
        adj_ext = {{(PHASE_WIDTH-ADJ_WIDTH){adj[ADJ_WIDTH-1]}}, adj};
        return base + adj_ext;
    endfunction

    state_t                   state, state_nxt;
    logic [2*PHASE_WIDTH-1:0] tdata_nxt;
    logic                     tvalid_nxt;
    logic                     pend, pend_nxt;
    logic [2*PHASE_WIDTH-1:0] pend_data, pend_data_nxt;
    logic [15:0]              cfg_nxt, drop_nxt;
    logic [2*PHASE_WIDTH-1:0] new_cfg;
    logic                     handshake;

    assign new_cfg   = {phase_off, pinc_wrap(freq_base, freq_adj)};
    assign handshake = CFG_tvalid && CFG_tready;

    always_comb begin
        state_nxt     = state;
        tdata_nxt     = CFG_tdata;
        tvalid_nxt    = CFG_tvalid;
        pend_nxt      = pend;
        pend_data_nxt = pend_data;
        cfg_nxt       = cfg_count;
        drop_nxt      = drop_count;

        case (state)
            INIT: begin
                tdata_nxt  = {{PHASE_WIDTH{1'b0}}, freq_base};
                tvalid_nxt = 1'b1;
                state_nxt  = SEND;
            end
            IDLE: begin
                tvalid_nxt = 1'b0;
                if (adj_valid) begin
                    tdata_nxt  = new_cfg;
                    tvalid_nxt = 1'b1;
                    state_nxt  = SEND;
                end
            end
            SEND: begin
                if (handshake) begin
                    cfg_nxt = cfg_count + 16'd1;
                    if (adj_valid) begin
                        // Fresh value bypasses the slot; a parked older value is lost.
                        tdata_nxt = new_cfg;
                        pend_nxt  = 1'b0;
                        if (pend) drop_nxt = drop_count + 16'd1;
                    end else if (pend) begin
                        tdata_nxt = pend_data;
                        pend_nxt  = 1'b0;
                    end else begin
                        tvalid_nxt = 1'b0;
                        state_nxt  = IDLE;
                    end
                end else if (adj_valid) begin
                    // Beat is stalled: park the update, latest wins.
                    pend_data_nxt = new_cfg;
                    pend_nxt      = 1'b1;
                    if (pend) drop_nxt = drop_count + 16'd1;
                end
            end
            default: begin
                tvalid_nxt = 1'b0;
                state_nxt  = INIT;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= INIT;
            CFG_tdata  <= '0;
            CFG_tvalid <= 1'b0;
            pend       <= 1'b0;
            cfg_count  <= '0;
            drop_count <= '0;
        end else begin
            state      <= state_nxt;
            CFG_tdata  <= tdata_nxt;
            CFG_tvalid <= tvalid_nxt;
            pend       <= pend_nxt;
            cfg_count  <= cfg_nxt;
            drop_count <= drop_nxt;
        end
    end

    // Slot contents are only meaningful while pend is set, so no reset needed.
    always_ff @(posedge clk) begin
        pend_data <= pend_data_nxt;
    end

endmodule

// File: tb/tb_nco_phase_config.sv
// tb_nco_phase_config
//   Directed scenarios plus randomized traffic for nco_phase_config, compared
//   cycle by cycle against a behavioural model of the config beat stream.
module tb_nco_phase_config;

    logic               clk;
    logic               rst_n;
    logic [31:0]        freq_base;
    logic signed [23:0] freq_adj;
    logic [31:0]        phase_off;
    logic               adj_valid;
    logic [63:0]        cfg_tdata;
    logic               cfg_tvalid;
    logic               cfg_tready;
    logic [15:0]        cfg_count;
    logic [15:0]        drop_count;

    int checks = 0;
    int errors = 0;

    // Behavioural model: the beat on the wire, one parked update, two tallies.
    bit          m_first;
    bit          m_valid;
    logic [63:0] m_data;
    bit          m_pend;
    logic [63:0] m_pdata;
    int          m_cfg;
    int          m_drop;

    nco_phase_config #(.PHASE_WIDTH(32), .ADJ_WIDTH(24)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .freq_base  (freq_base),
        .freq_adj   (freq_adj),
        .phase_off  (phase_off),
        .adj_valid  (adj_valid),
        .CFG_tdata  (cfg_tdata),
        .CFG_tvalid (cfg_tvalid),
        .CFG_tready (cfg_tready),
        .cfg_count  (cfg_count),
        .drop_count (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cfg_word(input logic [31:0] fb, input logic signed [23:0] fa,
                                             input logic [31:0] po);
        logic [31:0] pinc;
        pinc = fb + int'(fa);
        return {po, pinc};
    endfunction

    task automatic model_reset();
        m_first = 1'b1;
        m_valid = 1'b0;
        m_data  = '0;
        m_pend  = 1'b0;
        m_pdata = '0;
        m_cfg   = 0;
        m_drop  = 0;
    endtask

    task automatic model_edge();
        logic [63:0] nv;
        nv = cfg_word(freq_base, freq_adj, phase_off);
        if (m_first) begin
            m_first = 1'b0;
            m_valid = 1'b1;
            m_data  = {32'h0, freq_base};
        end else if (!m_valid) begin
            if (adj_valid) begin
                m_valid = 1'b1;
                m_data  = nv;
            end
        end else if (cfg_tready) begin
            m_cfg++;
            if (adj_valid) begin
                if (m_pend) m_drop++;
                m_pend = 1'b0;
                m_data = nv;
            end else if (m_pend) begin
                m_pend = 1'b0;
                m_data = m_pdata;
            end else begin
                m_valid = 1'b0;
            end
        end else if (adj_valid) begin
            if (m_pend) m_drop++;
            m_pend  = 1'b1;
            m_pdata = nv;
        end
    endtask

    // One clock: model advances on the edge, DUT compared 1 time unit later.
    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("tvalid", 64'(cfg_tvalid), 64'(m_valid));
        chk("tdata", cfg_tdata, m_data);
        chk("cfg_count", 64'(cfg_count), 64'(m_cfg[15:0]));
        chk("drop_count", 64'(drop_count), 64'(m_drop[15:0]));
    endtask

    task automatic drive(input logic [31:0] fb, input logic signed [23:0] fa,
                         input logic [31:0] po, input logic av, input logic rdy);
        freq_base  = fb;
        freq_adj   = fa;
        phase_off  = po;
        adj_valid  = av;
        cfg_tready = rdy;
    endtask

    initial begin
        logic [63:0] a_word, c_word;
        logic [15:0] cfg0, drop0;

        rst_n = 1'b0;
        drive(32'h0, 24'sd0, 32'h0, 1'b0, 1'b0);
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("rst_tdata", cfg_tdata, 64'd0);
        chk("rst_cfg", 64'(cfg_count), 64'd0);
        chk("rst_drop", 64'(drop_count), 64'd0);

        // Power-up beat carries the nominal carrier with zero offset.
        drive(32'h0CCCCCCD, 24'sd0, 32'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b1;
        step();
        chk("init_beat", cfg_tdata, 64'h00000000_0CCCCCCD);
        chk("init_valid", 64'(cfg_tvalid), 64'd1);
        step();
        chk("init_cfg", 64'(cfg_count), 64'd1);
        chk("init_idle", 64'(cfg_tvalid), 64'd0);

        // Negative correction.
        drive(32'h10000000, -24'sd256, 32'h40000000, 1'b1, 1'b0);
        step();
        chk("neg_adj", cfg_tdata, 64'h40000000_0FFFFF00);
        chk("neg_valid", 64'(cfg_tvalid), 64'd1);
        drive(32'h10000000, -24'sd256, 32'h40000000, 1'b0, 1'b1);
        step();

        // Increment wraps past 2^32.
        drive(32'hFFFFFF00, 24'sh000200, 32'h0, 1'b1, 1'b0);
        step();
        chk("wrap_pinc", 64'(cfg_tdata[31:0]), 64'h00000100);
        drive(32'hFFFFFF00, 24'sh000200, 32'h0, 1'b0, 1'b1);
        step();

        // Stall with A, B, C: A on the wire, B parked then replaced by C.
        cfg0   = cfg_count;
        drop0  = drop_count;
        a_word = cfg_word(32'h11111111, 24'sh000010, 32'hAAAA0000);
        c_word = cfg_word(32'h33333333, -24'sd3, 32'hCCCC0000);
        drive(32'h11111111, 24'sh000010, 32'hAAAA0000, 1'b1, 1'b0);
        step();
        drive(32'h22222222, 24'sh000020, 32'hBBBB0000, 1'b1, 1'b0);
        step();
        drive(32'h33333333, -24'sd3, 32'hCCCC0000, 1'b1, 1'b0);
        step();
        drive(32'h44444444, 24'sd0, 32'h0, 1'b0, 1'b0);
        repeat (7) step();
        chk("stall_hold", cfg_tdata, a_word);
        chk("stall_drop", 64'(drop_count - drop0), 64'd1);
        cfg_tready = 1'b1;
        step();
        chk("stall_c_sent", cfg_tdata, c_word);
        chk("stall_c_valid", 64'(cfg_tvalid), 64'd1);
        step();
        chk("stall_cfg", 64'(cfg_count - cfg0), 64'd2);
        chk("stall_idle", 64'(cfg_tvalid), 64'd0);

        // Update coincident with handshake while a value is parked.
        drop0 = drop_count;
        drive(32'h01000000, 24'sd1, 32'h00000001, 1'b1, 1'b0);
        step();
        drive(32'h02000000, 24'sd2, 32'h00000002, 1'b1, 1'b0);
        step();
        drive(32'h03000000, 24'sd3, 32'h00000003, 1'b1, 1'b1);
        step();
        chk("coin_data", cfg_tdata, 64'h00000003_03000003);
        chk("coin_valid", 64'(cfg_tvalid), 64'd1);
        chk("coin_drop", 64'(drop_count - drop0), 64'd1);
        drive(32'h03000000, 24'sd0, 32'h0, 1'b0, 1'b1);
        step();

        // Randomized traffic, including freq_base churn without adj_valid.
        for (int i = 0; i < 400; i++) begin
            drive($urandom, 24'($urandom), $urandom,
                  1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 1)));
            step();
        end

        // Asynchronous reset in the middle of a stalled beat.
        drive(32'h0000ABCD, 24'sd5, 32'h5, 1'b1, 1'b0);
        step();
        drive(32'h0000ABCD, 24'sd5, 32'h5, 1'b0, 1'b0);
        step();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        chk("arst_tvalid", 64'(cfg_tvalid), 64'd0);
        chk("arst_tdata", cfg_tdata, 64'd0);
        chk("arst_cfg", 64'(cfg_count), 64'd0);
        chk("arst_drop", 64'(drop_count), 64'd0);
        #2 rst_n = 1'b1;
        freq_base  = 32'h12345678;
        cfg_tready = 1'b1;
        step();
        chk("arst_init_beat", cfg_tdata, 64'h00000000_12345678);
        step();
        chk("arst_init_cfg", 64'(cfg_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nco_phase_config.md
NCO_PHASE_CONFIG -- requirements
Module: nco_phase_config

Interface
REQ-001 Parameter PHASE_WIDTH, default 32, SHALL set the width of the phase-increment and phase-offset fields.
REQ-002 Parameter ADJ_WIDTH, default 24, SHALL set the width of the signed frequency-adjust input.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  SHALL be an asynchronous, active-low reset.
REQ-005 freq_base  input  PHASE_WIDTH  SHALL be the unsigned nominal phase increment (carrier).
REQ-006 freq_adj  input  ADJ_WIDTH  SHALL be the signed loop-filter correction to the phase increment.
REQ-007 phase_off  input  PHASE_WIDTH  SHALL be the unsigned phase offset.
REQ-008 adj_valid  input  1  SHALL mark freq_adj and phase_off as valid for one cycle.
REQ-009 CFG_tdata  output  2*PHASE_WIDTH  SHALL carry {POFF, PINC}: PINC in [PHASE_WIDTH-1:0], POFF in [2*PHASE_WIDTH-1:PHASE_WIDTH].
REQ-010 CFG_tvalid  output  1  SHALL be the AXI-Stream valid toward the NCO config port.
REQ-011 CFG_tready  input  1  SHALL be the AXI-Stream ready from the NCO config port.
REQ-012 cfg_count  output  16  SHALL count accepted config beats.
REQ-013 drop_count  output  16  SHALL count computed updates overwritten before being sent.

Function
REQ-014 PINC SHALL equal freq_base + sign-extended freq_adj, modulo 2^PHASE_WIDTH (wrap, no saturation).
REQ-015 The FSM SHALL have states INIT, IDLE, SEND.
REQ-016 INIT: first clk edge after rst_n release SHALL load CFG_tdata = {0, freq_base}, set CFG_tvalid=1, go to SEND.
REQ-017 IDLE: CFG_tvalid=0; adj_valid at edge t SHALL load the computed {phase_off, PINC} into CFG_tdata and assert CFG_tvalid at t+1 (latency 1), go to SEND.
REQ-018 SEND: CFG_tdata and CFG_tvalid SHALL be held stable until the cycle CFG_tvalid && CFG_tready.
REQ-019 Handshake with no pending update and no adj_valid that cycle: next cycle CFG_tvalid=0, state IDLE.
REQ-020 adj_valid while in SEND without handshake: value SHALL go to a one-entry pending register; pending flag set.
REQ-021 adj_valid while pending already set and no handshake: pending SHALL be overwritten (latest wins); drop_count +1.
REQ-022 Handshake with pending set: next cycle CFG_tdata = pending, CFG_tvalid stays 1, pending cleared, state SEND.
REQ-023 Handshake coincident with adj_valid: the new value SHALL load CFG_tdata directly; any older pending value SHALL be discarded with drop_count +1; CFG_tvalid stays 1.
REQ-024 cfg_count SHALL increment by 1 on each handshake; both counters wrap at 2^16.
REQ-025 CFG_tvalid SHALL never deassert without a completed handshake (except reset).
REQ-026 freq_base changes without adj_valid SHALL NOT produce a config beat.

Reset
REQ-027 rst_n low SHALL immediately force CFG_tvalid=0, CFG_tdata=0, pending=0, cfg_count=0, drop_count=0, state INIT.
REQ-028 Reset asserted mid-SEND SHALL abandon the beat; after release, INIT behaviour of REQ-016 repeats.

Verification
REQ-029 Reset release, freq_base=0x0CCCCCCD, CFG_tready=1 -> one beat {0x00000000,0x0CCCCCCD}, cfg_count=1, then CFG_tvalid=0.
REQ-030 IDLE, freq_base=0x10000000, freq_adj=-256, phase_off=0x40000000, adj_valid 1 cycle -> next cycle CFG_tdata={0x40000000,0x0FFFFF00}, CFG_tvalid=1.
REQ-031 Wrap: freq_base=0xFFFFFF00, freq_adj=+0x200 -> PINC=0x00000100.
REQ-032 CFG_tready=0 for 10 cycles, adj_valid with A, B, C during stall -> tdata held; after ready, beat sent then C sent; drop_count=1 (B), cfg_count +2.
REQ-033 adj_valid coincident with handshake, pending set -> new value in tdata next cycle, tvalid continuous, drop_count +1.
REQ-034 rst_n pulsed low during stalled SEND -> tvalid=0 asynchronously, counters 0, fresh INIT beat after release.
